// File: rtl/disparity_scheduler.sv
// Stereo SSD disparity search sequencer: walks the frame two columns at a time,
// sweeps disparity offsets through an SSD engine and emits the per-lane minimum.
module disparity_scheduler #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int MIN_OFFSET = 4,
  parameter int MAX_OFFSET = 10,
  parameter int SCALE      = 25,
  parameter int LINE_GAP   = 160,
  parameter int SSD_W      = 21
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             eng_req_valid,
  input  logic             eng_req_ready,
  output logic [8:0]       eng_row,
  output logic [8:0]       eng_col,
  output logic [4:0]       eng_offset,
  input  logic             eng_rsp_valid,
  input  logic [SSD_W-1:0] eng_ssd_0,
  input  logic [SSD_W-1:0] eng_ssd_1,
  output logic             pix_valid,
  output logic [7:0]       DATA_0,
  output logic [7:0]       DATA_1,
  output logic             HSYNC
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, EMIT, GAP
  } state_t;

  localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((LINE_GAP == 0) ? 0 : LINE_GAP - 1);
  localparam logic [SSD_W-1:0] SSD_INIT = '1;
  localparam logic [4:0] OFF_MIN = 5'(MIN_OFFSET);
  localparam logic [4:0] OFF_MAX = 5'(MAX_OFFSET);

  state_t           state, state_nx;
  logic [8:0]       row, col;
  logic [4:0]       offset;
  logic [SSD_W-1:0] best_ssd_0, best_ssd_1;
  logic [4:0]       best_off_0, best_off_1;
  logic [GW-1:0]    gap_cnt;
  logic             done_q;
  logic [7:0]       data_0_q, data_1_q;

  logic       upd_0, upd_1;
  logic [4:0] nb_off_0, nb_off_1;
  logic       last_off, last_col, last_row;

  function automatic logic [7:0] scale_sat(input logic [4:0] off);
    logic [15:0] p;
    p = 16'(off) * 16'(SCALE);
    return (p > 16'd255) ? 8'hFF : p[7:0];
  endfunction

  always_comb begin
    upd_0    = eng_ssd_0 < best_ssd_0;
    upd_1    = eng_ssd_1 < best_ssd_1;
    nb_off_0 = upd_0 ? offset : best_off_0;
    nb_off_1 = upd_1 ? offset : best_off_1;
    last_off = offset == OFF_MAX;
    last_col = col == 9'(WIDTH - 2);
    last_row = row == 9'(HEIGHT - 1);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: if (eng_req_ready) state_nx = WAIT;
      WAIT:  if (eng_rsp_valid) state_nx = last_off ? EMIT : ISSUE;
      EMIT: begin
        if (!last_col)
          state_nx = ISSUE;
        else if (!last_row)
          state_nx = (LINE_GAP == 0) ? ISSUE : GAP;
        else
          state_nx = IDLE;
      end
      GAP:   if (gap_cnt == GAP_LAST) state_nx = ISSUE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      offset     <= '0;
      best_ssd_0 <= SSD_INIT;
      best_ssd_1 <= SSD_INIT;
      best_off_0 <= OFF_MIN;
      best_off_1 <= OFF_MIN;
      gap_cnt    <= '0;
      done_q     <= 1'b0;
      data_0_q   <= '0;
      data_1_q   <= '0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          row        <= '0;
          col        <= '0;
          offset     <= OFF_MIN;
          best_ssd_0 <= SSD_INIT;
          best_ssd_1 <= SSD_INIT;
          best_off_0 <= OFF_MIN;
          best_off_1 <= OFF_MIN;
        end
        WAIT: if (eng_rsp_valid) begin
          if (upd_0) best_ssd_0 <= eng_ssd_0;
          if (upd_1) best_ssd_1 <= eng_ssd_1;
          best_off_0 <= nb_off_0;
          best_off_1 <= nb_off_1;
          // Result is latched here so it is valid during the EMIT cycle.
          if (last_off) begin
            data_0_q <= scale_sat(nb_off_0);
            data_1_q <= scale_sat(nb_off_1);
          end else begin
            offset <= offset + 5'd1;
          end
        end
        EMIT: begin
          offset     <= OFF_MIN;
          best_ssd_0 <= SSD_INIT;
          best_ssd_1 <= SSD_INIT;
          best_off_0 <= OFF_MIN;
          best_off_1 <= OFF_MIN;
          gap_cnt    <= '0;
          if (!last_col) begin
            col <= col + 9'd2;
          end else if (!last_row) begin
            col <= '0;
            row <= row + 9'd1;
          end else begin
            col    <= '0;
            row    <= '0;
            done_q <= 1'b1;
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy          = state != IDLE;
  assign done          = done_q;
  assign eng_req_valid = state == ISSUE;
  assign eng_row       = row;
  assign eng_col       = col;
  assign eng_offset    = offset;
  assign pix_valid     = state == EMIT;
  assign DATA_0        = data_0_q;
  assign DATA_1        = data_1_q;
  assign HSYNC         = state == GAP;

endmodule

// File: tb/tb_disparity_scheduler.sv
// Randomized bench for disparity_scheduler: behavioural SSD engine plus
// argmin reference model over a per-frame SSD table.
module tb_disparity_scheduler;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int MINO = 4;
  localparam int MAXO = 10;
  localparam int SC   = 30;
  localparam int LG   = 3;
  localparam int SW   = 21;
  localparam int NOFF = MAXO - MINO + 1;
  localparam int NPR  = (W / 2) * H;

  logic          HCLK = 1'b0;
  logic          HRESET, start;
  logic          busy, done;
  logic          eng_req_valid, eng_req_ready;
  logic [8:0]    eng_row, eng_col;
  logic [4:0]    eng_offset;
  logic          eng_rsp_valid;
  logic [SW-1:0] eng_ssd_0, eng_ssd_1;
  logic          pix_valid, HSYNC;
  logic [7:0]    DATA_0, DATA_1;

  disparity_scheduler #(
    .WIDTH(W), .HEIGHT(H), .MIN_OFFSET(MINO), .MAX_OFFSET(MAXO),
    .SCALE(SC), .LINE_GAP(LG), .SSD_W(SW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .busy(busy), .done(done),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready),
    .eng_row(eng_row), .eng_col(eng_col), .eng_offset(eng_offset),
    .eng_rsp_valid(eng_rsp_valid),
    .eng_ssd_0(eng_ssd_0), .eng_ssd_1(eng_ssd_1),
    .pix_valid(pix_valid), .DATA_0(DATA_0), .DATA_1(DATA_1),
    .HSYNC(HSYNC)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_err = 0;

  logic [SW-1:0] tbl [NPR][2][NOFF];
  int bp_mode  = 0;
  int rand_lat = 0;
  int req_idx, pix_idx, hs_cnt, done_cnt;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Spec rule: first offset holding the minimum; all-ones never wins.
  function automatic int exp_byte(input int pair, input int lane);
    logic [SW-1:0] m;
    int bo, v;
    m  = '1;
    bo = MINO;
    foreach (tbl[pair][lane][k])
      if (tbl[pair][lane][k] < m) m = tbl[pair][lane][k];
    if (m != {SW{1'b1}}) begin
      for (int k = NOFF - 1; k >= 0; k--)
        if (tbl[pair][lane][k] == m) bo = MINO + k;
    end
    v = bo * SC;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [SW-1:0] gen(input int mode, input int lane,
                                        input int off);
    int tgt;
    case (mode)
      0: return SW'($urandom_range(0, 3));
      1: return SW'(100);
      2: return '1;
      3: return SW'($urandom);
      default: begin
        tgt = (mode == 4) ? ((lane == 0) ? 7 : 9)
                          : ((lane == 0) ? 10 : 8);
        return (off == tgt) ? SW'(10) : SW'(1000 + off);
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  // Engine model: accepts requests, answers after 1..3 cycles.
  initial begin : engine
    logic          acc, pend, stall;
    logic [23:0]   held;
    int            cnt, rp, ro, hold_n;
    acc = 0; pend = 0; stall = 0; held = '0;
    cnt = 0; rp = 0; ro = 0; hold_n = 0;
    eng_req_ready = 1'b0;
    eng_rsp_valid = 1'b0;
    eng_ssd_0 = '0;
    eng_ssd_1 = '0;
    forever begin
      @(negedge HCLK);
      eng_rsp_valid = 1'b0;
      if (HRESET) begin
        acc = 0;
        pend = 0;
      end
      if (acc) begin
        pend = 1;
        acc  = 0;
        cnt  = (rand_lat != 0) ? int'($urandom_range(0, 2)) : 0;
      end
      if (pend) begin
        if (cnt == 0) begin
          eng_rsp_valid = 1'b1;
          eng_ssd_0 = tbl[rp][0][ro];
          eng_ssd_1 = tbl[rp][1][ro];
          pend = 0;
        end else begin
          cnt--;
        end
      end
      if (stall && !HRESET)
        chk("req_hold", {eng_req_valid, eng_row, eng_col, eng_offset}, held);
      if (eng_offset != 5'd6) hold_n = 0;
      case (bp_mode)
        1: eng_req_ready = $urandom_range(0, 2) != 0;
        2: begin
          eng_req_ready = !(eng_req_valid && eng_offset == 5'd6 && hold_n < 5);
          if (!eng_req_ready) hold_n++;
        end
        default: eng_req_ready = 1'b1;
      endcase
      stall = eng_req_valid && !eng_req_ready && !HRESET;
      held  = {eng_req_valid, eng_row, eng_col, eng_offset};
      if (eng_req_valid && eng_req_ready && !HRESET) begin
        acc = 1;
        rp  = (req_idx / NOFF) % NPR;
        ro  = req_idx % NOFF;
        chk("req_row", eng_row, rp / (W / 2));
        chk("req_col", eng_col, 2 * (rp % (W / 2)));
        chk("req_off", eng_offset, MINO + ro);
        req_idx++;
      end
    end
  end

  initial begin : monitor
    logic prev_pix;
    prev_pix = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESET) begin
        if (pix_valid) begin
          if (pix_idx < NPR) begin
            chk("data0", DATA_0, exp_byte(pix_idx, 0));
            chk("data1", DATA_1, exp_byte(pix_idx, 1));
          end else begin
            chk("pix_extra", pix_idx, NPR - 1);
          end
          pix_idx++;
        end else if (pix_idx > 0 && pix_idx <= NPR) begin
          chk("hold0", DATA_0, exp_byte(pix_idx - 1, 0));
          chk("hold1", DATA_1, exp_byte(pix_idx - 1, 1));
        end
        if (HSYNC) begin
          hs_cnt++;
          chk("hsync_pos", pix_idx, W / 2);
        end
        if (done) begin
          done_cnt++;
          chk("done_time", {prev_pix, 8'(pix_idx)}, {1'b1, 8'(NPR)});
          chk("done_busy", busy, 0);
        end
        prev_pix = pix_valid;
      end
    end
  end

  task automatic begin_frame(input int mode, input int bp, input int lat);
    foreach (tbl[p, l, k]) tbl[p][l][k] = gen(mode, l, k + MINO);
    bp_mode  = bp;
    rand_lat = lat;
    req_idx  = 0;
    pix_idx  = 0;
    hs_cnt   = 0;
    done_cnt = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", {busy, eng_req_valid}, 2'b11);
  endtask

  task automatic finish_frame(input bit inject);
    if (inject) begin
      repeat (30) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick;
    repeat (4) tick;
    chk("done_cnt", done_cnt, 1);
    chk("pix_cnt", pix_idx, NPR);
    chk("req_cnt", req_idx, NPR * NOFF);
    chk("hsync_cnt", hs_cnt, LG * (H - 1));
    chk("idle_busy", busy, 0);
  endtask

  task automatic chk_reset_outs;
    chk("rst_ctrl", {busy, done, eng_req_valid, pix_valid, HSYNC}, 0);
    chk("rst_req", {eng_row, eng_col, eng_offset}, 0);
    chk("rst_data", {DATA_0, DATA_1}, 0);
  endtask

  initial begin
    HRESET = 1'b1;
    start  = 1'b0;
    req_idx = 0; pix_idx = 0; hs_cnt = 0; done_cnt = 0;
    foreach (tbl[p, l, k]) tbl[p][l][k] = '1;
    repeat (3) tick;
    chk_reset_outs();
    HRESET = 1'b0;
    tick;

    begin_frame(4, 0, 0); finish_frame(0);
    chk("min7_9", {DATA_0, DATA_1}, {8'd210, 8'd255});
    begin_frame(1, 0, 0); finish_frame(0);
    chk("tie_const", {DATA_0, DATA_1}, {8'd120, 8'd120});
    begin_frame(2, 2, 0); finish_frame(0);
    chk("tie_ones", {DATA_0, DATA_1}, {8'd120, 8'd120});
    begin_frame(5, 1, 1); finish_frame(0);
    chk("sat_min10", {DATA_0, DATA_1}, {8'd255, 8'd240});
    begin_frame(0, 1, 1); finish_frame(1);

    begin_frame(3, 1, 1);
    repeat (25) tick;
    HRESET = 1'b1;
    repeat (3) tick;
    chk_reset_outs();
    HRESET = 1'b0;
    begin_frame(3, 1, 1); finish_frame(0);
    begin_frame(0, 2, 1); finish_frame(1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
